addsub_chunked: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor that processes the operands one CHUNK-bit digit per clock, LSB digit first, through a registered carry. It generalises the team's 4-bit combinational add/sub into a WIDTH-bit unit with a start/done handshake and full status flags. It is the ALU arithmetic path where area matters more than latency. It sits between the register-file read stage and the writeback mux.

---
 rtl/addsub_chunked.sv | 137 +++++++++++++
 tb/tb_addsub_chunked.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock, LSB digit first.
// Optional build macro ADDSUB_SATURATE_EN clamps the result on signed overflow.
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [CHUNK:0]   dsum;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] final_sum;
  logic             raw_ovfl;
  logic             last;

  // Operand registers shift right each digit, so the active digit is always in the low CHUNK bits.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovfl_d    = ovfl_q;
    zero_d    = zero_q;
    done_d    = 1'b0;

    dsum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    raw       = (res_q >> CHUNK) | (WIDTH'(dsum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last      = (cnt_q == CNT_W'(N - 1));
    // On the last digit a_q/b_q low chunk holds the operand MSB digit.
    raw_ovfl  = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (dsum[CHUNK-1] != a_q[CHUNK-1]);
    final_sum = raw;
`ifdef ADDSUB_SATURATE_EN
    if (raw_ovfl) begin
      final_sum = a_q[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = raw;
        carry_d = dsum[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sum_d   = final_sum;
          cout_d  = dsum[CHUNK];
          ovfl_d  = raw_ovfl;
          zero_d  = (final_sum == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovfl = ovfl_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Self-checking bench for addsub_chunked (WIDTH=16, CHUNK=4); honours ADDSUB_SATURATE_EN.
module tb_addsub_chunked;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovfl;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovfl(ovfl), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on the true mathematical result.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                       output logic [15:0] e_sum, output logic e_cout,
                       output logic e_ovfl, output logic e_zero);
    int sa, sb, tr, ua, ub;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    tr = ms ? sa - sb : sa + sb;
    e_ovfl = (tr > 32767) || (tr < -32768);
    e_cout = ms ? (ua >= ub) : (ua + ub > 65535);
    e_sum  = tr[15:0];
`ifdef ADDSUB_SATURATE_EN
    if (e_ovfl) e_sum = (tr > 0) ? 16'h7FFF : 16'h8000;
`endif
    e_zero = (e_sum == 16'h0000);
  endtask

  // Launch one operation; returns edges from accept to done and whether outputs/busy held during RUN.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                       output int lat, output bit run_ok);
    logic [18:0] snap;
    @(negedge clk);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    snap = {sum, cout, ovfl, zero};
    lat = 0;
    run_ok = busy;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!done && ({sum, cout, ovfl, zero} !== snap || busy !== 1'b1)) run_ok = 0;
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] oa, input logic [15:0] ob,
                          input logic os, input int lat, input bit run_ok);
    logic [15:0] e_sum;
    logic e_cout, e_ovfl, e_zero;
    model(oa, ob, os, e_sum, e_cout, e_ovfl, e_zero);
    n_tests++;
    if (lat !== 4 || run_ok !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s timing: latency=%0d run_ok=%0d busy=%0b, required latency=4 run_ok=1 busy=0",
               name, lat, run_ok, busy);
    end
    n_tests++;
    if ({sum, cout, ovfl, zero} !== {e_sum, e_cout, e_ovfl, e_zero}) begin
      n_fail++;
      $display("FAIL %s result: sum=%h cout=%b ovfl=%b zero=%b, required sum=%h cout=%b ovfl=%b zero=%b",
               name, sum, cout, ovfl, zero, e_sum, e_cout, e_ovfl, e_zero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, sum, cout, ovfl, zero} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovfl=%b zero=%b, required all 0",
               busy, done, sum, cout, ovfl, zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat; bit ok;
    do_op(16'h1234, 16'h0FED, 1'b0, lat, ok); check_op("add_basic", 16'h1234, 16'h0FED, 1'b0, lat, ok);
    n_tests++;
    if (sum !== 16'h2221) begin
      n_fail++; $display("FAIL add_basic_const: sum=%h, required 2221", sum);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done);
    end
    do_op(16'h0005, 16'h0007, 1'b1, lat, ok); check_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, lat, ok);
    n_tests++;
    if ({sum, cout} !== {16'hFFFE, 1'b0}) begin
      n_fail++; $display("FAIL sub_borrow_const: sum=%h cout=%b, required FFFE 0", sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap; bit ok;
    do_op(16'h1234, 16'h1234, 1'b1, lat, ok); check_op("zero_result", 16'h1234, 16'h1234, 1'b1, lat, ok);
    n_tests++;
    if ({sum, zero, cout} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL zero_result_const: sum=%h zero=%b cout=%b, required 0000 1 1", sum, zero, cout);
    end
    // Start held during the done cycle.
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    n_tests++;
    if (gap !== 5 || sum !== 16'h0002 || zero !== 1'b0) begin
      n_fail++; $display("FAIL back_to_back: gap=%0d sum=%h zero=%b, required gap=5 sum=0002 zero=0", gap, sum, zero);
    end
  endtask

  task automatic test_overflow();
    int lat; bit ok;
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, ok); check_op("pos_ovfl", 16'h7FFF, 16'h0001, 1'b0, lat, ok);
    n_tests++;
`ifdef ADDSUB_SATURATE_EN
    if ({sum, ovfl, cout} !== {16'h7FFF, 1'b1, 1'b0}) begin
`else
    if ({sum, ovfl, cout} !== {16'h8000, 1'b1, 1'b0}) begin
`endif
      n_fail++; $display("FAIL pos_ovfl_const: sum=%h ovfl=%b cout=%b", sum, ovfl, cout);
    end
    do_op(16'h8000, 16'h0001, 1'b1, lat, ok); check_op("neg_ovfl", 16'h8000, 16'h0001, 1'b1, lat, ok);
    n_tests++;
`ifdef ADDSUB_SATURATE_EN
    if ({sum, ovfl, cout} !== {16'h8000, 1'b1, 1'b1}) begin
`else
    if ({sum, ovfl, cout} !== {16'h7FFF, 1'b1, 1'b1}) begin
`endif
      n_fail++; $display("FAIL neg_ovfl_const: sum=%h ovfl=%b cout=%b", sum, ovfl, cout);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b1;   // start stays high while busy
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 3) start = 1'b0;             // dropped before the done cycle
    end
    n_tests++;
    if (lat !== 4 || sum !== 16'h0007) begin
      n_fail++; $display("FAIL busy_ignore: latency=%0d sum=%h, required 4 0007", lat, sum);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; bit ok; bit saw_done;
    saw_done = 0;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;      // accepted at edge k
    @(negedge clk);
    a = 16'h4444; b = 16'h1234; sub = 1'b1;                    // extra start at k+1
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00FF;                                // extra start at k+2
    @(negedge clk);
    saw_done = saw_done | done;
    start = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, sum, cout, ovfl, zero} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b done=%b sum=%h cout=%b ovfl=%b zero=%b, required all 0",
               busy, done, sum, cout, ovfl, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++; $display("FAIL reset_discard: done/busy seen=1 after reset, required 0");
    end
    do_op(16'h0003, 16'h0004, 1'b0, lat, ok); check_op("after_reset", 16'h0003, 16'h0004, 1'b0, lat, ok);
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [15:0] ra, rb; logic rs;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;                         // steer some zero results
      if (i % 8 == 1) begin ra = 16'h7FF0 | 16'($urandom_range(0, 15)); rb = 16'h0010; rs = 1'b0; end
      do_op(ra, rb, rs, lat, ok);
      check_op("random", ra, rb, rs, lat, ok);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_overflow();
    test_busy_ignore();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
